// File: rtl/render_frame_writer_pkg.sv
// Shared constants, FSM encoding and ordered-dither table for the 3D-region frame buffer writer.
package render_pkg;

    localparam int FRAME_W      = 634 - 390;
    localparam int FRAME_H      = 765 - 390;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    typedef enum logic {
        WRITE     = 1'b0,
        WAIT_SWAP = 1'b1
    } fsm_t;

    // 2x2 Bayer threshold, indexed by {row parity, column parity}
    function automatic logic [7:0] bayer(input logic [1:0] idx);
        case (idx)
            2'b00:   bayer = 8'd0;
            2'b01:   bayer = 8'd8;
            2'b10:   bayer = 8'd12;
            default: bayer = 8'd4;
        endcase
    endfunction

endpackage

// File: rtl/render_frame_writer_if.sv
// Renderer pixel stream: 24b RGB with screen coordinates and a valid/ready handshake.
interface render_frame_writer_if;
    logic [23:0] s_pixel_tdata;
    logic        s_pixel_tvalid;
    logic        s_pixel_tready;
    logic [10:0] s_hcount;
    logic [9:0]  s_vcount;

    modport master (
        output s_pixel_tdata, s_pixel_tvalid, s_hcount, s_vcount,
        input  s_pixel_tready
    );

    modport slave (
        input  s_pixel_tdata, s_pixel_tvalid, s_hcount, s_vcount,
        output s_pixel_tready
    );
endinterface

// File: rtl/render_frame_writer_pixel_pack.sv
// Combinational 24b RGB -> 12b {R4,G4,B4}; RENDER_FRAME_WRITER_DITHER_EN adds 2x2 ordered dither.
module pixel_pack
    import render_pkg::*;
(
    input  logic [23:0] rgb,
    input  logic [1:0]  phase,
    output logic [11:0] packed_rgb
);

`ifdef RENDER_FRAME_WRITER_DITHER_EN
    // Bias then keep the top nibble; a carry out clamps to full scale.
    function automatic logic [3:0] dither_ch(input logic [7:0] ch, input logic [7:0] bias);
        logic [8:0] sum;
        sum = {1'b0, ch} + {1'b0, bias};
        return sum[8] ? 4'hF : sum[7:4];
    endfunction

    logic [7:0] bias;
    assign bias       = bayer(phase);
    assign packed_rgb = {dither_ch(rgb[23:16], bias),
                         dither_ch(rgb[15:8],  bias),
                         dither_ch(rgb[7:0],   bias)};
`else
    logic unused_bits;
    assign unused_bits = ^{phase, rgb[19:16], rgb[11:8], rgb[3:0]};
    assign packed_rgb  = {rgb[23:20], rgb[15:12], rgb[7:4]};
`endif

endmodule

// File: rtl/render_frame_writer.sv
// Double-buffered frame writer: packs renderer pixels into the write bank, swaps banks on scanout new-frame.
// Optional ordered dither is enabled by defining RENDER_FRAME_WRITER_DITHER_EN.
module render_frame_writer
    import render_pkg::*;
#(
    parameter int START_X       = 390,
    parameter int START_Y       = 390,
    parameter int END_X         = 634,
    parameter int END_Y         = 765,
    parameter int REGION_DIVIDE = 530,
    parameter int CYL_SHIFT     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    render_frame_writer_if.slave pix,
    input  logic              nf_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [11:0]       wr_data_out,
    output logic              wr_en_out,
    output logic              rd_bank_out,
    output logic              frame_done_out,
    output logic [15:0]       drop_count_out
);

    fsm_t state, state_next;
    logic wr_bank;
    logic swap;
    logic accept, in_window, last_pixel;
    logic signed [11:0] col;
    logic signed [10:0] row;
    logic [11:0] pix12;
    logic [ADDR_W-1:0] addr_next;

    pixel_pack u_pack (
        .rgb        (pix.s_pixel_tdata),
        .phase      ({pix.s_vcount[0], pix.s_hcount[0]}),
        .packed_rgb (pix12)
    );

    assign pix.s_pixel_tready = (state == WRITE) && !rst_in;
    assign accept             = pix.s_pixel_tvalid && pix.s_pixel_tready;

    // Cylinder rows are rendered two columns to the right; pull them back into frame coordinates.
    always_comb begin
        col = $signed({1'b0, pix.s_hcount} - 12'(START_X)
                      - ((pix.s_vcount < 10'(REGION_DIVIDE)) ? 12'(CYL_SHIFT) : 12'd0));
        row = $signed({1'b0, pix.s_vcount} - 11'(START_Y));
        in_window  = !col[11] && (col[10:0] < 11'(FRAME_W)) &&
                     !row[10] && (row[9:0]  < 10'(FRAME_H));
        addr_next  = (wr_bank ? ADDR_W'(FRAME_PIXELS) : '0)
                   + ADDR_W'(row[9:0]) * ADDR_W'(FRAME_W)
                   + ADDR_W'(col[10:0]);
        last_pixel = (pix.s_hcount == 11'(END_X - 1)) && (pix.s_vcount == 10'(END_Y - 1));
    end

    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            WRITE:     if (accept && last_pixel) state_next = WAIT_SWAP;
            WAIT_SWAP: if (nf_in) begin
                           swap       = 1'b1;
                           state_next = WRITE;
                       end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= WRITE;
            wr_bank        <= 1'b1;
            rd_bank_out    <= 1'b0;
            frame_done_out <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            drop_count_out <= '0;
        end else begin
            state          <= state_next;
            frame_done_out <= swap;
            if (swap) begin
                rd_bank_out <= wr_bank;
                wr_bank     <= ~wr_bank;
            end
            wr_en_out <= accept && in_window;
            if (accept && in_window) begin
                wr_addr_out <= addr_next;
                wr_data_out <= pix12;
            end
            if (accept && !in_window && drop_count_out != 16'hFFFF)
                drop_count_out <= drop_count_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_render_frame_writer.sv
// Scoreboard bench for render_frame_writer: expected writes queued at drive time, popped at the output.
module tb_render_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf  = 1'b0;
    logic [17:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en, rd_bank, frame_done;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    render_frame_writer_if pix();

    render_frame_writer dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .pix            (pix),
        .nf_in          (nf),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .wr_en_out      (wr_en),
        .rd_bank_out    (rd_bank),
        .frame_done_out (frame_done),
        .drop_count_out (drop_count)
    );

    typedef struct {
        int          addr;
        logic [11:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   tb_bank  = 1;
    int   exp_drop = 0;

    function automatic int model_addr(int bank, int h, int v);
        int c, r;
        c = h - 390 - ((v < 530) ? 2 : 0);
        r = v - 390;
        if (c < 0 || c >= 244 || r < 0 || r >= 375) return -1;
        return bank * 91500 + r * 244 + c;
    endfunction

    function automatic logic [11:0] model_data(logic [23:0] d, int h, int v);
        logic [11:0] res;
        int ch, t, b;
        b = 0;
`ifdef RENDER_FRAME_WRITER_DITHER_EN
        case ((v % 2) * 2 + (h % 2))
            0: b = 0;
            1: b = 8;
            2: b = 12;
            default: b = 4;
        endcase
`endif
        for (int k = 0; k < 3; k++) begin
            ch = int'(d[8*k +: 8]);
            t  = ch + b;
            if (t > 255) t = 255;
            res[4*k +: 4] = 4'(t / 16);
        end
        return res;
    endfunction

    // Drives one pixel for a single clock edge and records what the writer should do with it.
    task automatic send(input logic [23:0] d, input int h, input int v, input logic nf_val);
        int a;
        @(negedge clk);
        pix.s_pixel_tdata  = d;
        pix.s_hcount       = 11'(h);
        pix.s_vcount       = 10'(v);
        pix.s_pixel_tvalid = 1'b1;
        nf                 = nf_val;
        a = model_addr(tb_bank, h, v);
        if (a >= 0) sb.push_back('{a, model_data(d, h, v)});
        else if (exp_drop < 65535) exp_drop++;
        @(posedge clk);
        #1;
        pix.s_pixel_tvalid = 1'b0;
        nf                 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (pix.s_pixel_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", pix.s_pixel_tready); end
        n_cmp++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL rst_rd_bank: got %b expected 0", rd_bank); end
        n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (pix.s_pixel_tready !== 1'b1) begin n_fail++; $display("FAIL rel_tready: got %b expected 1", pix.s_pixel_tready); end
    endtask

    task automatic test_window_write();
        logic [23:0] d[4] = '{24'hF0A050, 24'h123456, 24'hABCDEF, 24'h0F1E2D};
        int          h[4] = '{390, 392, 633, 390};
        int          v[4] = '{600, 400, 600, 764};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(d[i], h[i], v[i], 1'b0);
            n_cmp++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL win_en[%0d]: got %b expected 1", i, wr_en); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++; if (wr_addr !== 18'(e.addr)) begin n_fail++; $display("FAIL win_addr[%0d]: got %0d expected %0d", i, wr_addr, e.addr); end
                n_cmp++; if (wr_data !== e.data) begin n_fail++; $display("FAIL win_data[%0d]: got %h expected %h", i, wr_data, e.data); end
            end else begin
                n_cmp++; n_fail++; $display("FAIL win_sb[%0d]: got empty queue expected one write", i);
            end
            if (i == 0) begin
                n_cmp++; if (wr_addr !== 18'd142740) begin n_fail++; $display("FAIL win_first_addr: got %0d expected 142740", wr_addr); end
`ifndef RENDER_FRAME_WRITER_DITHER_EN
                n_cmp++; if (wr_data !== 12'hFA5) begin n_fail++; $display("FAIL win_first_data: got %h expected fa5", wr_data); end
`endif
            end
            if (i == 1) begin
                n_cmp++; if (wr_addr !== 18'd93940) begin n_fail++; $display("FAIL win_cyl_addr: got %0d expected 93940", wr_addr); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL win_idle_en: got %b expected 0", wr_en); end
    endtask

    task automatic test_drop();
        int h[5] = '{390, 634, 389, 400, 2047};
        int v[5] = '{400, 600, 600, 389, 765};
        for (int i = 0; i < 5; i++) begin
            send(24'h555555, h[i], v[i], 1'b0);
            n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_en[%0d]: got %b expected 0", i, wr_en); end
            n_cmp++; if (drop_count !== 16'(exp_drop)) begin n_fail++; $display("FAIL drop_cnt[%0d]: got %0d expected %0d", i, drop_count, exp_drop); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send(24'($urandom), 400 + i, 700 + (i % 2), 1'b0);
            n_cmp++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_en[%0d]: got %b expected 1", i, wr_en); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++; if (wr_addr !== 18'(e.addr)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, wr_addr, e.addr); end
                n_cmp++; if (wr_data !== e.data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wr_data, e.data); end
            end
        end
    endtask

    task automatic test_dither();
        exp_t e;
        send(24'h787878, 391, 600, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_data !== e.data) begin n_fail++; $display("FAIL dith_model: got %h expected %h", wr_data, e.data); end
        end
`ifdef RENDER_FRAME_WRITER_DITHER_EN
        n_cmp++; if (wr_data !== 12'h888) begin n_fail++; $display("FAIL dith_const: got %h expected 888", wr_data); end
`else
        n_cmp++; if (wr_data !== 12'h777) begin n_fail++; $display("FAIL dith_const: got %h expected 777", wr_data); end
`endif
        send(24'hFFFFFF, 391, 601, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_data !== e.data) begin n_fail++; $display("FAIL dith_sat: got %h expected %h", wr_data, e.data); end
        end
    endtask

    task automatic test_swap();
        exp_t e;
        send(24'h102030, 633, 764, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_addr !== 18'(e.addr)) begin n_fail++; $display("FAIL swap_last_addr: got %0d expected %0d", wr_addr, e.addr); end
        end
        n_cmp++; if (pix.s_pixel_tready !== 1'b0) begin n_fail++; $display("FAIL swap_stall: got %b expected 0", pix.s_pixel_tready); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (rd_bank !== 1'b0 || pix.s_pixel_tready !== 1'b0) begin n_fail++; $display("FAIL swap_wait: got bank %b ready %b expected 0 0", rd_bank, pix.s_pixel_tready); end
        @(negedge clk); nf = 1'b1;
        @(posedge clk); #1; nf = 1'b0;
        tb_bank = 0;
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL swap_done: got %b expected 1", frame_done); end
        n_cmp++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL swap_rd_bank: got %b expected 1", rd_bank); end
        n_cmp++; if (pix.s_pixel_tready !== 1'b1) begin n_fail++; $display("FAIL swap_ready: got %b expected 1", pix.s_pixel_tready); end
        @(posedge clk); #1;
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL swap_pulse: got %b expected 0", frame_done); end
        send(24'hF0A050, 390, 600, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_addr !== 18'(e.addr)) begin n_fail++; $display("FAIL swap_bank0_model: got %0d expected %0d", wr_addr, e.addr); end
        end
        n_cmp++; if (wr_addr !== 18'd51240) begin n_fail++; $display("FAIL swap_bank0_addr: got %0d expected 51240", wr_addr); end
    endtask

    task automatic test_nf_coincident();
        exp_t e;
        send(24'h445566, 633, 764, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_addr !== 18'(e.addr)) begin n_fail++; $display("FAIL coin_addr: got %0d expected %0d", wr_addr, e.addr); end
        end
        n_cmp++; if (rd_bank !== 1'b1 || frame_done !== 1'b0) begin n_fail++; $display("FAIL coin_noswap: got bank %b done %b expected 1 0", rd_bank, frame_done); end
        @(posedge clk); #1;
        n_cmp++; if (pix.s_pixel_tready !== 1'b0) begin n_fail++; $display("FAIL coin_stall: got %b expected 0", pix.s_pixel_tready); end
        @(negedge clk); nf = 1'b1;
        @(posedge clk); #1; nf = 1'b0;
        tb_bank = 1;
        n_cmp++; if (frame_done !== 1'b1 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL coin_swap: got done %b bank %b expected 1 0", frame_done, rd_bank); end
    endtask

    task automatic test_nf_ignored();
        @(negedge clk); nf = 1'b1;
        @(posedge clk); #1; nf = 1'b0;
        n_cmp++; if (frame_done !== 1'b0 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL nfw_ignored: got done %b bank %b expected 0 0", frame_done, rd_bank); end
        n_cmp++; if (pix.s_pixel_tready !== 1'b1) begin n_fail++; $display("FAIL nfw_ready: got %b expected 1", pix.s_pixel_tready); end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        tb_bank = 0;
        send(24'h111111, 633, 764, 1'b0);
        @(negedge clk); nf = 1'b1;
        @(posedge clk); #1; nf = 1'b0;
        sb.delete();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        tb_bank  = 1;
        exp_drop = 0;
        n_cmp++; if (rd_bank !== 1'b0 || drop_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst: got bank %b drop %0d expected 0 0", rd_bank, drop_count); end
        send(24'hF0A050, 390, 600, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if (wr_addr !== 18'd142740 || wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_addr: got %0d en %b expected %0d 1", wr_addr, wr_en, e.addr); end
        end
    endtask

    initial begin
        pix.s_pixel_tvalid = 1'b0;
        pix.s_pixel_tdata  = '0;
        pix.s_hcount       = '0;
        pix.s_vcount       = '0;
        test_reset();
        test_window_write();
        test_drop();
        test_back_to_back();
        test_dither();
        test_swap();
        test_nf_coincident();
        test_nf_ignored();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
